mem_fill_writer: RTL and testbench

Memory fill engine: on a start pulse, writes a Galois-LFSR data sequence into consecutive words of a synchronous single-port RAM write port. It keeps a running 32-bit checksum of the accepted words. It is the write-side counterpart of the sum-memory readers: a reader summing the same region must reproduce `checksum`. It sits between top-level control (button-driven start) and the RAM write port, and honours a write-ready handshake.

---
 rtl/mem_fill_pkg.sv | 18 +
 rtl/mem_fill_writer_lfsr32.sv | 23 ++
 rtl/mem_fill_writer.sv | 123 ++++++++++++
 tb/tb_mem_fill_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// Shared definitions for the memory fill writer and its reader-side checkers:
// FSM state encoding, default LFSR polynomial and the LFSR step function.
package mem_fill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

   // One Galois step: shift right, fold the polynomial in when a one drops out.
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input logic [31:0] poly);
      return cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
   endfunction

endpackage

// File: rtl/mem_fill_writer_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; an all-zero load value becomes 1
// so the register can never lock up in the zero state.
module lfsr32
   import mem_fill_pkg::*;
#(
   parameter logic [31:0] POLY = DEFAULT_POLY
) (
   input  logic        clk,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        advance,
   output logic [31:0] q
);

   always_ff @(posedge clk) begin
      if (load) begin
         q <= (load_val == 32'd0) ? 32'd1 : load_val;
      end else if (advance) begin
         q <= lfsr_next(q, POLY);
      end
   end

endmodule

// File: rtl/mem_fill_writer.sv
// Fills consecutive RAM words with an LFSR sequence after a start pulse,
// honouring wr_ready and keeping a 32-bit running sum of accepted words.
module mem_fill_writer
   import mem_fill_pkg::*;
#(
   parameter int          AWIDTH = 10,
   parameter int          DWIDTH = 32,
   parameter int          DEPTH  = 1024,
   parameter logic [31:0] POLY   = DEFAULT_POLY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [31:0]       size,
   input  logic [31:0]       seed,
   input  logic              wr_ready,
   output logic              we,
   output logic [AWIDTH-1:0] waddr,
   output logic [DWIDTH-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       checksum
);

   // One extra bit so a count of exactly DEPTH (== 2^AWIDTH) is representable.
   localparam int          CW      = AWIDTH + 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] n_words;
   logic [CW-1:0] n_eff;
   logic [31:0]   lfsr_q;
   logic [31:0]   wdata_ext;
   logic [31:0]   lfsr_load_val;
   logic          lfsr_load;
   logic          start_acc;
   logic          accept;
   logic          last_word;

   assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign accept    = (state == ST_WRITE) && wr_ready;
   assign last_word = ({1'b0, waddr} + CW'(1)) == n_words;
   assign n_eff     = (size > DEPTH_W) ? DEPTH_W[CW-1:0] : size[CW-1:0];

   // Reset reuses the load path: a zero load value lands the LFSR on 1.
   assign lfsr_load     = !reset_n || start_acc;
   assign lfsr_load_val = reset_n ? seed : 32'd0;

   lfsr32 #(
      .POLY(POLY)
   ) u_lfsr (
      .clk     (clk),
      .load    (lfsr_load),
      .load_val(lfsr_load_val),
      .advance (accept),
      .q       (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = (n_eff == '0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wr_ready && last_word) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      wdata_ext               = '0;
      wdata_ext[DWIDTH-1:0]   = lfsr_q[DWIDTH-1:0];
   end

   // The address parks on the final word rather than stepping past DEPTH-1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         waddr    <= '0;
         checksum <= '0;
         n_words  <= '0;
      end else if (start_acc) begin
         waddr    <= '0;
         checksum <= '0;
         n_words  <= n_eff;
      end else if (accept) begin
         checksum <= checksum + wdata_ext;
         if (!last_word) begin
            waddr <= waddr + AWIDTH'(1);
         end
      end
   end

   always_comb begin
      we   = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_WRITE: begin
            we   = 1'b1;
            busy = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
      wdata = we ? wdata_ext[DWIDTH-1:0] : '0;
   end

endmodule

// File: tb/tb_mem_fill_writer.sv
// Bench for mem_fill_writer: directed plan steps plus randomized fills,
// each write compared against an arithmetic model of the LFSR fill.
module tb_mem_fill_writer;

   localparam logic [31:0] POLY = 32'h80200003;
   localparam int          DEPTH = 1024;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] size;
   logic [31:0] seed;
   logic        wr_ready;
   logic        we;
   logic [9:0]  waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   int          passes;
   int          total;
   int          last_wcycles;
   logic [31:0] last_sum;
   logic [9:0]  last_addr;

   mem_fill_writer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .size    (size),
      .seed    (seed),
      .wr_ready(wr_ready),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // mode 0: always ready, 1: ready on odd WRITE cycles (first high), 2: random
   task automatic run_fill(input logic [31:0] sd, input logic [31:0] sz, input int mode,
                           input bit poke_start, input string tag);
      logic [31:0] lf;
      logic [31:0] sum;
      logic [9:0]  prev_a;
      logic [31:0] prev_d;
      bit          prev_stall;
      bit          rdy;
      int          n;
      int          idx;
      int          guard;
      int          limit;
      n          = (sz > DEPTH) ? DEPTH : int'(sz);
      lf         = (sd == 32'd0) ? 32'd1 : sd;
      sum        = 32'd0;
      idx        = 0;
      guard      = 0;
      limit      = 8 * n + 40;
      prev_stall = 1'b0;
      prev_a     = '0;
      prev_d     = '0;
      seed       = sd;
      size       = sz;
      wr_ready   = 1'b0;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         check({tag, "_done"}, done, 1);
         check({tag, "_we"}, we, 0);
         check({tag, "_sum"}, checksum, 0);
         @(posedge clk); #1;
         check({tag, "_we_after"}, we, 0);
         last_sum     = 32'd0;
         last_wcycles = 0;
         return;
      end
      last_wcycles = 0;
      while (idx < n && guard < limit) begin
         guard++;
         check({tag, "_we"}, we, 1);
         if (!we) break;
         check({tag, "_addr"}, waddr, idx);
         check({tag, "_data"}, wdata, lf);
         if (prev_stall) begin
            check({tag, "_hold_addr"}, waddr, prev_a);
            check({tag, "_hold_data"}, wdata, prev_d);
         end
         last_wcycles++;
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = (last_wcycles % 2) == 1;
         else                rdy = 1'($urandom_range(0, 1));
         wr_ready = rdy;
         if (poke_start && last_wcycles == 2) begin
            start = 1'b1;
            seed  = $urandom;
            size  = 32'd3;
         end
         prev_a     = waddr;
         prev_d     = wdata;
         prev_stall = !rdy;
         if (rdy) begin
            sum       = sum + lf;
            lf        = ref_step(lf);
            last_addr = waddr;
            idx++;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check({tag, "_count"}, idx, n);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_we_end"}, we, 0);
      check({tag, "_sum"}, checksum, sum);
      wr_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done_hold"}, done, 1);
      check({tag, "_sum_frozen"}, checksum, sum);
      last_sum = sum;
   endtask

   initial begin
      passes   = 0;
      total    = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      size     = 32'd0;
      seed     = 32'd0;
      wr_ready = 1'b0;
      last_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_sum", checksum, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_we", we, 0);

      run_fill(32'd1, 32'd4, 0, 1'b0, "basic");
      check("basic_const", checksum, 32'hA0680007);

      run_fill(32'd1, 32'd4, 1, 1'b0, "stall");
      check("stall_cycles", last_wcycles, 7);
      check("stall_const", checksum, 32'hA0680007);

      run_fill(32'd7, 32'd0, 0, 1'b0, "size0");

      run_fill(32'h1234_5678, 32'd5000, 0, 1'b0, "clamp");
      check("clamp_last_addr", last_addr, 10'd1023);

      run_fill(32'd0, 32'd4, 0, 1'b0, "seed0");
      check("seed0_const", checksum, 32'hA0680007);

      run_fill(32'd1, 32'd2, 0, 1'b0, "restart");
      check("restart_const", checksum, 32'h80200004);

      run_fill(32'hDEAD_BEEF, 32'd9, 2, 1'b1, "ignore");

      // Reset after word 2 of an 8-word fill is accepted.
      seed     = 32'd1;
      size     = 32'd8;
      wr_ready = 1'b1;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_addr_before", waddr, 3);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("mid_we", we, 0);
      check("mid_waddr", waddr, 0);
      check("mid_sum", checksum, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_wdata", wdata, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("mid_idle_we", we, 0);
      run_fill(32'd1, 32'd4, 0, 1'b0, "refill");

      for (int i = 0; i < 6; i++) begin
         run_fill($urandom, 32'($urandom_range(0, 40)), 2, 1'($urandom_range(0, 1)), "rand");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
